// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
//   MULT_DATA_WIDTH : default operand width
//   booth_digit_t   : recoded Booth digit (0, +A, +2A, -A, -2A)
//   booth_decode    : maps a multiplier triplet {b[2k+1], b[2k], b[2k-1]} to its digit
package mult_pkg;

    localparam int MULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    function automatic booth_digit_t booth_decode(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;  // 000 and 111
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_if.sv
// Operand/result bundle of the Booth multiplier.
//   i_a : multiplicand, unsigned, DATA_WIDTH bits
//   i_b : multiplier, unsigned, DATA_WIDTH bits
//   o_c : registered product, 2*DATA_WIDTH bits
// Handshake: none. There is no valid/ready; every clock's i_a/i_b pair is
// consumed and its product appears on o_c three rising edges later.
interface booth_mult_if #(
    parameter int DATA_WIDTH = mult_pkg::MULT_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0]   i_a;
    logic [DATA_WIDTH-1:0]   i_b;
    logic [2*DATA_WIDTH-1:0] o_c;

    // master drives the operands and observes the product
    modport master (output i_a, output i_b, input o_c);
    // slave is the multiplier itself
    modport slave  (input i_a, input i_b, output o_c);

endinterface

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product generator.
//   a       : multiplicand (unsigned, DATA_WIDTH bits)
//   triplet : {b[2k+1], b[2k], b[2k-1]} of the zero-extended multiplier
//   pp      : signed partial product in 2*DATA_WIDTH-bit two's complement,
//             not yet shifted by 2k
module booth_pp_gen #(
    parameter int DATA_WIDTH = mult_pkg::MULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [2:0]              triplet,
    output logic [2*DATA_WIDTH-1:0] pp
);
    import mult_pkg::*;

    logic [2*DATA_WIDTH-1:0] a1;
    logic [2*DATA_WIDTH-1:0] a2;
    booth_digit_t            digit;

    // Zero-extend first so the multiplicand is never read as negative.
    assign a1    = {{DATA_WIDTH{1'b0}}, a};
    assign a2    = a1 << 1;
    assign digit = booth_decode(triplet);

    always_comb begin
        pp = '0;
        case (digit)
            POS1:    pp = a1;
            POS2:    pp = a2;
            NEG1:    pp = ~a1 + 1'b1;
            NEG2:    pp = ~a2 + 1'b1;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult.sv
// Fully pipelined radix-4 Booth multiplier, unsigned operands, full-width
// product, fixed latency of three rising edges, one product per cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every pipeline register
//   bus   : booth_mult_if.slave carrying i_a, i_b (inputs) and o_c (output)
// Pipeline:
//   edge 1 : a_q/b_q  <- i_a/i_b
//   edge 2 : pp_q[k]  <- Booth partial product k, shifted by 2k
//   edge 3 : c_q      <- sum of pp_q (modulo 2^(2*DATA_WIDTH)), drives o_c
module booth_mult #(
    parameter int DATA_WIDTH = mult_pkg::MULT_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    booth_mult_if.slave  bus
);
    import mult_pkg::*;

    localparam int PW     = 2 * DATA_WIDTH;
    // Multiplier is zero-extended by two bits, so the top digit is never negative.
    localparam int NUM_PP = (DATA_WIDTH + 2) / 2;

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    // {00, b, b[-1]=0}: index 0 holds the implicit b[-1].
    logic [DATA_WIDTH+2:0] b_ext;
    logic [PW-1:0]         pp_raw [NUM_PP];
    logic [PW-1:0]         pp_q   [NUM_PP];
    logic [PW-1:0]         sum;
    logic [PW-1:0]         c_q;

    // Stage 1: operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= bus.i_a;
            b_q <= bus.i_b;
        end
    end

    assign b_ext = {2'b00, b_q, 1'b0};

    genvar k;
    generate
        for (k = 0; k < NUM_PP; k++) begin : g_pp
            booth_pp_gen #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_pp_gen (
                .a       (a_q),
                .triplet (b_ext[2*k+2 : 2*k]),
                .pp      (pp_raw[k])
            );
        end
    endgenerate

    // Stage 2: shifted partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PP; i++) begin
                pp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PP; i++) begin
                pp_q[i] <= pp_raw[i] << (2 * i);
            end
        end
    end

    // Reduction: plain modular sum; bits shifted past PW fall away naturally.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            sum = sum + pp_q[i];
        end
    end

    // Stage 3: product register, o_c comes straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= sum;
        end
    end

    assign bus.o_c = c_q;

endmodule

// File: tb/tb_booth_mult.sv
// Directed and random bench for booth_mult. Inputs are driven and outputs
// sampled on the falling edge; exp_q holds the product expected on o_c at
// each of the next three falling edges.
module tb_booth_mult;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [2*W-1:0] exp_q[$];

  booth_mult_if #(.DATA_WIDTH(W)) bus ();

  booth_mult #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  // scoreboard compare
  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one clock per call; check the product due now, then apply a new pair
  task automatic cyc(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] e, input string tag);
    logic [2*W-1:0] due;
    @(negedge clk);
    due = exp_q.pop_front();
    check(tag, bus.o_c, due);
    bus.i_a = a;
    bus.i_b = b;
    exp_q.push_back(e);
  endtask

  // release reset on a falling edge with 0x0 applied; pipeline shows zeros meanwhile
  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    bus.i_a = '0;
    bus.i_b = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] rp;

    // reset held with arbitrary inputs
    bus.i_a = 32'hDEADBEEF;
    bus.i_b = 32'h12345678;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", bus.o_c, 64'd0);
    end

    release_reset();
    cyc(32'd0, 32'd1, 64'd0, "zero_after_reset");
    cyc(32'd1, 32'd0, 64'd0, "zero_after_reset");
    cyc(32'd342, 32'd25, 64'd8550, "zero_after_reset");
    // 0x1 result arrives here; 342x25 must not yet be visible
    cyc(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "zero_a");
    cyc(32'h80000000, 32'd2, 64'h0000000100000000, "zero_b");
    cyc(32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, "typical_342x25");
    cyc(32'd7, 32'hFFFFFFFF, 64'h00000006FFFFFFF9, "max_x_max");
    cyc(32'hAAAAAAAA, 32'd3, 64'h00000001FFFFFFFE, "unsigned_msb");
    cyc(32'd1, 32'hFFFFFFFF, 64'h00000000FFFFFFFF, "ffff_sq");
    cyc(32'd0, 32'd0, 64'd0, "seven_x_max");
    cyc(32'd0, 32'd0, 64'd0, "aaaa_x3");
    cyc(32'd0, 32'd0, 64'd0, "one_x_max");

    // throughput: new random pair every cycle
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom_range(32'hFFFFFFFF, 0);
      rp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      cyc(ra, rb, rp, "random_stream");
    end
    repeat (3) cyc(32'd0, 32'd0, 64'd0, "random_stream");

    // asynchronous clear while a product is on o_c
    cyc(32'd342, 32'd25, 64'd8550, "flush");
    cyc(32'd0, 32'd0, 64'd0, "flush");
    cyc(32'd0, 32'd0, 64'd0, "flush");
    cyc(32'd0, 32'd0, 64'd0, "async_pre_8550");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", bus.o_c, 64'd0);

    // reset one cycle after driving 342x25: product must be discarded
    release_reset();
    cyc(32'd342, 32'd25, 64'd0, "mid_pre");
    @(negedge clk);
    void'(exp_q.pop_front());
    check("mid_pre", bus.o_c, 64'd0);
    rst_n   = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    #1;
    check("mid_reset_clear", bus.o_c, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_reset_hold", bus.o_c, 64'd0);
    end
    release_reset();
    repeat (5) cyc(32'd0, 32'd0, 64'd0, "mid_no_stale");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
